// File: rtl/svo_tmds_rx_pkg.sv
// Shared TMDS control tokens, FSM state type and offset helper for the svo_tmds receive path.
package svo_tmds_rx_pkg;

  // Wire order is bit 0 first; values match the svo_tmds encoder.
  localparam logic [9:0] SVO_TMDS_CTRL0 = 10'h354;
  localparam logic [9:0] SVO_TMDS_CTRL1 = 10'h0AB;
  localparam logic [9:0] SVO_TMDS_CTRL2 = 10'h154;
  localparam logic [9:0] SVO_TMDS_CTRL3 = 10'h2AB;

  typedef enum logic {StSearch, StLocked} rx_state_e;

  function automatic logic [3:0] next_offset(input logic [3:0] off);
    return (off == 4'd9) ? 4'd0 : off + 4'd1;
  endfunction

endpackage

// File: rtl/svo_tmds_rx_dec.sv
// Registered TMDS symbol decoder: one aligned 10-bit word in, pixel byte / DE / ctrl out.
import svo_tmds_rx_pkg::*;

module svo_tmds_rx_dec (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [9:0] word_i,
  output logic       is_tok_o,
  output logic [1:0] tok_code_o,
  output logic [7:0] dout_o,
  output logic       de_o,
  output logic [1:0] ctrl_o,
  output logic       sym_err_o
);

  logic [7:0] t;
  logic [7:0] d;
  logic       many_trans;
  logic [7:0] dout_q;
  logic       de_q;
  logic [1:0] ctrl_q;
  logic       sym_err_q;

  always_comb begin
    is_tok_o   = 1'b1;
    tok_code_o = 2'd0;
    unique case (word_i)
      SVO_TMDS_CTRL0: tok_code_o = 2'd0;
      SVO_TMDS_CTRL1: tok_code_o = 2'd1;
      SVO_TMDS_CTRL2: tok_code_o = 2'd2;
      SVO_TMDS_CTRL3: tok_code_o = 2'd3;
      default:        is_tok_o   = 1'b0;
    endcase

    t    = word_i[9] ? ~word_i[7:0] : word_i[7:0];
    d    = 8'h00;
    d[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = word_i[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end

    // Data symbols never exceed 5 transitions; tokens have 7 or more.
    many_trans = $countones(word_i[8:0] ^ word_i[9:1]) >= 7;
  end

  always_ff @(posedge clk) begin
    if (reset || !en_i) begin
      dout_q    <= 8'h00;
      de_q      <= 1'b0;
      ctrl_q    <= 2'd0;
      sym_err_q <= 1'b0;
    end else begin
      de_q      <= !is_tok_o;
      dout_q    <= is_tok_o ? 8'h00 : d;
      sym_err_q <= !is_tok_o && many_trans;
      if (is_tok_o) begin
        ctrl_q <= tok_code_o;
      end
    end
  end

  assign dout_o    = dout_q;
  assign de_o      = de_q;
  assign ctrl_o    = ctrl_q;
  assign sym_err_o = sym_err_q;

endmodule

// File: rtl/svo_tmds_rx.sv
// One TMDS receive lane: hunts control-token runs to find the word boundary, then decodes.
import svo_tmds_rx_pkg::*;

module svo_tmds_rx #(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned LOCK_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       de,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] offset,
  output logic       sym_err
);

  localparam int unsigned RunW = $clog2(CTRL_RUN + 1);
  localparam int unsigned WinW = $clog2(SEARCH_WINDOW);
  localparam int unsigned TmoW = $clog2(LOCK_TIMEOUT);

  rx_state_e       state_q;
  logic [9:0]      din_q;
  logic [19:0]     window;
  logic [9:0]      word;
  logic [3:0]      offset_q;
  logic [RunW-1:0] run_cnt_q;
  logic [RunW-1:0] run_cnt_d;
  logic [1:0]      prev_code_q;
  logic [WinW-1:0] win_cnt_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic            is_tok;
  logic [1:0]      tok_code;
  logic            run_hit;

  // Older word sits in the low half so bit index grows with arrival time.
  assign window = {din, din_q};
  assign word   = 10'(window >> offset_q);

  // prev_code_q is only meaningful while run_cnt_q is non-zero.
  always_comb begin
    run_cnt_d = '0;
    if (is_tok) begin
      if (run_cnt_q != '0 && tok_code == prev_code_q) begin
        run_cnt_d = (run_cnt_q == RunW'(CTRL_RUN)) ? run_cnt_q : run_cnt_q + RunW'(1);
      end else begin
        run_cnt_d = RunW'(1);
      end
    end
    run_hit = (run_cnt_d == RunW'(CTRL_RUN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StSearch;
      din_q       <= '0;
      offset_q    <= '0;
      run_cnt_q   <= '0;
      prev_code_q <= '0;
      win_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      din_q       <= din;
      run_cnt_q   <= run_cnt_d;
      prev_code_q <= tok_code;
      unique case (state_q)
        StSearch: begin
          if (run_hit) begin
            state_q   <= StLocked;
            tmo_cnt_q <= '0;
            win_cnt_q <= '0;
          end else if (win_cnt_q == WinW'(SEARCH_WINDOW - 1)) begin
            offset_q  <= next_offset(offset_q);
            win_cnt_q <= '0;
            run_cnt_q <= '0;
          end else begin
            win_cnt_q <= win_cnt_q + WinW'(1);
          end
        end
        StLocked: begin
          if (run_hit) begin
            tmo_cnt_q <= '0;
          end else if (tmo_cnt_q == TmoW'(LOCK_TIMEOUT - 1)) begin
            state_q   <= StSearch;
            offset_q  <= next_offset(offset_q);
            win_cnt_q <= '0;
            run_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  assign locked = (state_q == StLocked);
  assign offset = offset_q;

  svo_tmds_rx_dec u_dec (
    .clk        (clk),
    .reset      (reset),
    .en_i       (locked),
    .word_i     (word),
    .is_tok_o   (is_tok),
    .tok_code_o (tok_code),
    .dout_o     (dout),
    .de_o       (de),
    .ctrl_o     (ctrl),
    .sym_err_o  (sym_err)
  );

endmodule

// File: tb/tb_svo_tmds_rx.sv
// Loopback bench: TMDS-encodes bytes/tokens, serializes at a chosen bit offset, checks the lane.
module tb_svo_tmds_rx;

  localparam int unsigned CtrlRun      = 8;
  localparam int unsigned SearchWindow = 64;
  localparam int unsigned LockTimeout  = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic       de;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offset;
  logic       sym_err;

  svo_tmds_rx #(
    .CTRL_RUN      (CtrlRun),
    .SEARCH_WINDOW (SearchWindow),
    .LOCK_TIMEOUT  (LockTimeout)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .dout    (dout),
    .de      (de),
    .ctrl    (ctrl),
    .locked  (locked),
    .offset  (offset),
    .sym_err (sym_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [9:0] tok_tbl [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  bit bitq[$];
  int enc_cnt = 0;
  bit cmp_en = 0;
  bit prev_valid = 0;
  bit prev_data = 0;
  logic [7:0] prev_byte = '0;
  logic [1:0] prev_ctrl = '0;
  logic [1:0] exp_ctrl = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference DVI TMDS encoder with running disparity.
  task automatic tmds_encode(input logic [7:0] d, output logic [9:0] q);
    int n1;
    int n1q;
    int n0q;
    logic [8:0] qm;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  task automatic reframe(input int s);
    bitq.delete();
    for (int i = 0; i < s; i++) bitq.push_back(1'b0);
  endtask

  // Appends one symbol to the serial stream and clocks out one raw word.
  task automatic send_raw(input logic [9:0] sym);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) bitq.push_back(sym[i]);
    for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
    din = w;
    @(posedge clk);
    #1;
  endtask

  // Outputs after a send reflect the symbol sent one call earlier.
  task automatic send_sym(input logic [9:0] sym, input bit is_data, input logic [7:0] b,
                          input logic [1:0] code);
    send_raw(sym);
    if (cmp_en && prev_valid) begin
      check("de", de, prev_data);
      check("dout", dout, prev_data ? prev_byte : 8'h00);
      check("ctrl", ctrl, prev_ctrl);
      check("sym_err_clean", sym_err, 1'b0);
    end
    if (!is_data) exp_ctrl = code;
    prev_valid = 1;
    prev_data  = is_data;
    prev_byte  = b;
    prev_ctrl  = exp_ctrl;
  endtask

  task automatic send_tok(input logic [1:0] code);
    send_sym(tok_tbl[code], 1'b0, 8'h00, code);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] q;
    tmds_encode(b, q);
    send_sym(q, 1'b1, b, 2'd0);
  endtask

  task automatic do_reset(input int s);
    reset = 1'b1;
    reframe(0);
    send_raw(10'h000);
    reset = 1'b0;
    reframe(s);
    cmp_en = 0;
    prev_valid = 0;
    exp_ctrl = 2'd0;
    enc_cnt = 0;
  endtask

  task automatic acquire(input string tag, input int bound, input logic [9:0] tok);
    int n = 0;
    while (!locked && n < bound) begin
      send_raw(tok);
      n++;
    end
    check(tag, locked, 1'b1);
    prev_valid = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    bit saw_lock;
    logic [1:0] code;

    // Reset state.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked, 1'b0);
    check("rst_offset", offset, 4'd0);
    check("rst_dout", dout, 8'h00);
    check("rst_de", de, 1'b0);
    check("rst_ctrl", ctrl, 2'd0);
    check("rst_sym_err", sym_err, 1'b0);

    // Repeated CTRL0 reframed at bit offset 3.
    do_reset(3);
    acquire("t1_lock", 4 * SearchWindow + CtrlRun + 2, tok_tbl[0]);
    check("t1_offset", offset, 4'd3);
    repeat (2) send_raw(tok_tbl[0]);
    check("t1_de", de, 1'b0);
    check("t1_ctrl", ctrl, 2'd0);

    // Directed data decode at offset 0.
    do_reset(0);
    acquire("t2_lock", CtrlRun + 4, tok_tbl[0]);
    check("t2_offset", offset, 4'd0);
    send_tok(2'd0);
    send_tok(2'd0);
    cmp_en = 1;
    send_sym(10'h100, 1'b1, 8'h00, 2'd0);
    send_sym(10'h1FF, 1'b1, 8'h01, 2'd0);
    send_tok(2'd0);
    send_tok(2'd0);

    // Encoder loopback at a random offset with line-like traffic.
    s = $urandom_range(0, 9);
    do_reset(s);
    acquire("t3_lock", 10 * SearchWindow + CtrlRun + 4, tok_tbl[0]);
    check("t3_offset", offset, 4'(s));
    repeat (3) send_tok(2'd0);
    cmp_en = 1;
    for (int line = 0; line < 6; line++) begin
      for (int px = 0; px < 40; px++) send_byte(8'($urandom));
      code = 2'($urandom);
      for (int b = 0; b < 12; b++) send_tok(code);
    end

    // Data-only stream: lock times out, offset advances, then relocks at s.
    cmp_en = 0;
    repeat (LockTimeout - 4) send_byte(8'($urandom));
    check("t4_still_locked", locked, 1'b1);
    repeat (8) send_byte(8'($urandom));
    check("t4_lock_dropped", locked, 1'b0);
    check("t4_offset_adv", offset, (s == 9) ? 4'd0 : 4'(s + 1));
    acquire("t4_relock", 10 * SearchWindow + CtrlRun + 4, tok_tbl[0]);
    check("t4_relock_offset", offset, 4'(s));

    // Runs one short of CTRL_RUN never lock; offset walks 0..9 and wraps.
    do_reset(0);
    saw_lock = 0;
    for (n = 1; n <= 10 * SearchWindow + SearchWindow / 2; n++) begin
      send_raw(((n - 1) % 10 < CtrlRun - 1) ? tok_tbl[0] : 10'h100);
      if (locked) saw_lock = 1;
      if (n % SearchWindow == SearchWindow / 2) begin
        check("t5_offset", offset, 4'((n / SearchWindow) % 10));
      end
    end
    check("t5_never_locked", saw_lock, 1'b0);

    // Lock at offset 7, exercise sym_err and ctrl, then a one-cycle reset.
    do_reset(7);
    acquire("t6_lock", 8 * SearchWindow + CtrlRun + 4, tok_tbl[0]);
    check("t6_offset", offset, 4'd7);
    send_raw(10'h155);
    send_raw(tok_tbl[0]);
    check("t6_sym_err", sym_err, 1'b1);
    check("t6_sym_err_de", de, 1'b1);
    send_raw(tok_tbl[3]);
    check("t6_sym_err_clear", sym_err, 1'b0);
    send_raw(tok_tbl[3]);
    check("t6_ctrl3", ctrl, 2'd3);
    reset = 1'b1;
    send_raw(tok_tbl[3]);
    reset = 1'b0;
    check("t6_rst_locked", locked, 1'b0);
    check("t6_rst_offset", offset, 4'd0);
    check("t6_rst_dout", dout, 8'h00);
    check("t6_rst_de", de, 1'b0);
    check("t6_rst_ctrl", ctrl, 2'd0);
    check("t6_rst_sym_err", sym_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
